// File: rtl/jtdd2_dwnld_if.sv
// rtl/jtdd2_dwnld_if.sv - ioctl download bus and SDRAM/PROM programming port bundle
// The loader drives through master; the translator sits on slave.
interface jtdd2_dwnld_if;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        prog_ack;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic        dwnld_busy;
  logic        ovf;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
    input  prog_addr, prog_data, prog_mask, prog_we, prom_we, dwnld_busy, ovf
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
    output prog_addr, prog_data, prog_mask, prog_we, prom_we, dwnld_busy, ovf
  );
endinterface

// File: rtl/jtdd2_dwnld.sv
// rtl/jtdd2_dwnld.sv - Double Dragon II download address translator and SDRAM write sequencer
// Relocates ioctl bytes into SDRAM word writes (plane pairs merged) or PROM pulses.
module jtdd2_dwnld #(
  parameter logic [21:0] CHAR_ADDR  = 22'h80000,
  parameter logic [21:0] SCRZW_ADDR = 22'h90000,
  parameter logic [21:0] SCRXY_ADDR = 22'hB0000,
  parameter logic [21:0] OBJWZ_ADDR = 22'hD0000,
  parameter logic [21:0] OBJXY_ADDR = 22'h130000,
  parameter logic [21:0] PROM_ADDR  = 22'h190000,
  parameter logic [21:0] SCR_SDRAM  = 22'h6_0000,
  parameter logic [21:0] OBJ_SDRAM  = 22'h8_0000
) (
  input  logic clk,
  input  logic rst_n,
  jtdd2_dwnld_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic        prom;
  } wr_t;

  function automatic wr_t decode(input logic [21:0] a, input logic [7:0] d);
    wr_t w;
    w.data = d;
    w.prom = 1'b0;
    w.mask = a[0] ? 2'b01 : 2'b10;
    if (a < CHAR_ADDR) begin
      w.addr = a >> 1;
    end else if (a < SCRZW_ADDR) begin
      w.addr = (CHAR_ADDR >> 1) + ((a - CHAR_ADDR) >> 1);
    end else if (a < SCRXY_ADDR) begin
      w.addr = SCR_SDRAM + (a - SCRZW_ADDR);
      w.mask = 2'b10;
    end else if (a < OBJWZ_ADDR) begin
      w.addr = SCR_SDRAM + (a - SCRXY_ADDR);
      w.mask = 2'b01;
    end else if (a < OBJXY_ADDR) begin
      w.addr = OBJ_SDRAM + (a - OBJWZ_ADDR);
      w.mask = 2'b10;
    end else if (a < PROM_ADDR) begin
      w.addr = OBJ_SDRAM + (a - OBJXY_ADDR);
      w.mask = 2'b01;
    end else begin
      w.addr = a - PROM_ADDR;
      w.mask = 2'b11;
      w.prom = 1'b1;
    end
    return w;
  endfunction

  state_t      state, next_state;
  wr_t         in_w, buf_w, src;
  logic        buf_valid;
  logic        load, push, pop, ovf_set;
  logic [21:0] addr_q;
  logic [7:0]  data_q;
  logic [1:0]  mask_q;
  logic        prom_q, ovf_q;

  assign in_w = decode(bus.ioctl_addr, bus.ioctl_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // IDLE and DROP share one rule: drain the buffer first, else take the live write.
  always_comb begin
    next_state = state;
    src        = in_w;
    load       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      REQ: begin
        if (bus.prog_ack) next_state = DROP;
        if (bus.ioctl_wr) begin
          if (buf_valid) ovf_set = 1'b1;
          else           push    = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        if (buf_valid) begin
          src  = buf_w;
          load = 1'b1;
          pop  = 1'b1;
          push = bus.ioctl_wr;
        end else if (bus.ioctl_wr) begin
          load = 1'b1;
        end
        if (load && !src.prom) next_state = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_w     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= 2'b11;
      prom_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push)     buf_valid <= 1'b1;
      else if (pop) buf_valid <= 1'b0;
      if (push) buf_w <= in_w;
      if (load) begin
        addr_q <= src.addr;
        data_q <= src.data;
        mask_q <= src.mask;
      end
      prom_q <= load & src.prom;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign bus.prog_addr  = addr_q;
  assign bus.prog_data  = data_q;
  assign bus.prog_mask  = mask_q;
  assign bus.prog_we    = (state == REQ);
  assign bus.prom_we    = prom_q;
  assign bus.ovf        = ovf_q;
  assign bus.dwnld_busy = bus.downloading | (state != IDLE) | buf_valid;

endmodule

// File: tb/tb_jtdd2_dwnld.sv
// tb/tb_jtdd2_dwnld.sv - bench for jtdd2_dwnld: region decode table plus handshake corner sequences
module tb_jtdd2_dwnld;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtdd2_dwnld_if bus();

  jtdd2_dwnld dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [21:0] a;
    logic [7:0]  d;
    logic [21:0] exp_addr;
    logic [1:0]  exp_mask;
    logic        exp_prom;
  } vec_t;

  vec_t vecs[13];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   acc_start;

  always @(posedge clk) if (bus.prog_we && bus.prog_ack) n_acc <= n_acc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [21:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{22'h000003, 8'h5A, 22'h000001, 2'b01, 1'b0};
    vecs[1]  = '{22'h07FFFF, 8'h11, 22'h03FFFF, 2'b01, 1'b0};
    vecs[2]  = '{22'h080000, 8'h22, 22'h040000, 2'b10, 1'b0};
    vecs[3]  = '{22'h08FFFF, 8'h33, 22'h047FFF, 2'b01, 1'b0};
    vecs[4]  = '{22'h090010, 8'h44, 22'h060010, 2'b10, 1'b0};
    vecs[5]  = '{22'h0B0010, 8'h55, 22'h060010, 2'b01, 1'b0};
    vecs[6]  = '{22'h0AFFFF, 8'h66, 22'h07FFFF, 2'b10, 1'b0};
    vecs[7]  = '{22'h0D0000, 8'h77, 22'h080000, 2'b10, 1'b0};
    vecs[8]  = '{22'h12FFFF, 8'h88, 22'h0DFFFF, 2'b10, 1'b0};
    vecs[9]  = '{22'h130000, 8'h99, 22'h080000, 2'b01, 1'b0};
    vecs[10] = '{22'h18FFFF, 8'hAA, 22'h0DFFFF, 2'b01, 1'b0};
    vecs[11] = '{22'h190005, 8'hBB, 22'h000005, 2'b11, 1'b1};
    vecs[12] = '{22'h3FFFFF, 8'hCC, 22'h26FFFF, 2'b11, 1'b1};

    bus.downloading = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_data  = '0;
    bus.ioctl_wr    = 1'b0;
    bus.prog_ack    = 1'b0;
    step(); step();
    check("rst_prog_addr", bus.prog_addr, 0);
    check("rst_prog_data", bus.prog_data, 0);
    check("rst_prog_mask", bus.prog_mask, 2'b11);
    check("rst_prog_we", bus.prog_we, 0);
    check("rst_prom_we", bus.prom_we, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_busy", bus.dwnld_busy, 0);
    rst_n = 1'b1;
    step();

    // first test-plan write with a 3-cycle ack delay
    bus.downloading = 1'b1;
    wr(22'h000003, 8'h5A);
    step();
    bus.ioctl_wr = 1'b0;
    check("t1_we", bus.prog_we, 1);
    check("t1_addr", bus.prog_addr, 1);
    check("t1_mask", bus.prog_mask, 2'b01);
    check("t1_data", bus.prog_data, 8'h5A);
    step(); step();
    check("t1_we_held", bus.prog_we, 1);
    bus.prog_ack = 1'b1;
    step();
    bus.prog_ack = 1'b0;
    check("t1_we_drop", bus.prog_we, 0);
    step();

    for (int i = 0; i < 13; i++) begin
      wr(vecs[i].a, vecs[i].d);
      step();
      bus.ioctl_wr = 1'b0;
      check($sformatf("v%0d_addr", i), bus.prog_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_data", i), bus.prog_data, vecs[i].d);
      check($sformatf("v%0d_prom_we", i), bus.prom_we, vecs[i].exp_prom);
      check($sformatf("v%0d_prog_we", i), bus.prog_we, !vecs[i].exp_prom);
      if (!vecs[i].exp_prom) begin
        check($sformatf("v%0d_mask", i), bus.prog_mask, vecs[i].exp_mask);
        bus.prog_ack = 1'b1;
      end
      step();
      bus.prog_ack = 1'b0;
      check($sformatf("v%0d_we_off", i), bus.prog_we, 0);
      check($sformatf("v%0d_prom_off", i), bus.prom_we, 0);
      step();
    end

    // ack in IDLE is ignored
    bus.prog_ack = 1'b1;
    step();
    bus.prog_ack = 1'b0;
    check("idle_ack_we", bus.prog_we, 0);
    step();

    // write during the DROP cycle is taken directly, not buffered
    wr(22'h000100, 8'h01);
    step();
    bus.ioctl_wr = 1'b0;
    bus.prog_ack = 1'b1;
    step();
    bus.prog_ack = 1'b0;
    wr(22'h000201, 8'h02);
    step();
    bus.ioctl_wr = 1'b0;
    check("drop_direct_we", bus.prog_we, 1);
    check("drop_direct_addr", bus.prog_addr, 22'h000100);
    check("drop_direct_mask", bus.prog_mask, 2'b01);
    bus.downloading = 1'b0;
    bus.prog_ack = 1'b1;
    step();
    bus.prog_ack = 1'b0;
    step();
    check("drop_direct_idle_busy", bus.dwnld_busy, 0);
    check("drop_direct_idle_we", bus.prog_we, 0);

    // overflow: one in REQ, one buffered, one dropped
    acc_start = n_acc;
    bus.downloading = 1'b1;
    wr(22'h000010, 8'hA1);
    step();
    wr(22'h000011, 8'hA2);
    step();
    wr(22'h000020, 8'hA3);
    step();
    bus.ioctl_wr = 1'b0;
    check("ovf_set", bus.ovf, 1);
    check("ovf_first_addr", bus.prog_addr, 22'h000008);
    check("ovf_first_data", bus.prog_data, 8'hA1);
    bus.downloading = 1'b0;
    step();
    check("ovf_hold_we", bus.prog_we, 1);
    bus.prog_ack = 1'b1;
    step();
    bus.prog_ack = 1'b0;
    check("ovf_drop1_we", bus.prog_we, 0);
    check("ovf_drop1_busy", bus.dwnld_busy, 1);
    step();
    check("ovf_second_we", bus.prog_we, 1);
    check("ovf_second_addr", bus.prog_addr, 22'h000008);
    check("ovf_second_mask", bus.prog_mask, 2'b01);
    check("ovf_second_data", bus.prog_data, 8'hA2);
    bus.prog_ack = 1'b1;
    step();
    bus.prog_ack = 1'b0;
    check("ovf_drop2_busy", bus.dwnld_busy, 1);
    step();
    check("ovf_idle_busy", bus.dwnld_busy, 0);
    step(); step();
    check("ovf_no_third_we", bus.prog_we, 0);
    check("ovf_write_count", n_acc - acc_start, 2);
    check("ovf_sticky", bus.ovf, 1);

    // asynchronous reset in the middle of a request
    wr(22'h090001, 8'h3C);
    step();
    bus.ioctl_wr = 1'b0;
    check("ar_we_before", bus.prog_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_we", bus.prog_we, 0);
    check("ar_addr", bus.prog_addr, 0);
    check("ar_data", bus.prog_data, 0);
    check("ar_mask", bus.prog_mask, 2'b11);
    check("ar_ovf", bus.ovf, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("ar_no_retry", bus.prog_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
